// File: rtl/pe_os_if.sv
// Operand, control and drain-chain bundle for one output-stationary PE.
// slave faces the PE; master faces whatever drives its inputs.
interface pe_os_if #(
  parameter int DW    = 16,
  parameter int ACC_W = 40,
  parameter int CW    = 8
);
  logic             top_valid_i;
  logic [CW-1:0]    top_cnt_i;
  logic [DW-1:0]    top_data_i;
  logic             left_valid_i;
  logic [CW-1:0]    left_cnt_i;
  logic             left_type_i;
  logic             left_precision_i;
  logic [DW-1:0]    left_data_i;
  logic             cap_i;
  logic             shift_i;
  logic             top_res_valid_i;
  logic [ACC_W-1:0] top_res_i;
  logic             bot_valid_o;
  logic [CW-1:0]    bot_cnt_o;
  logic [DW-1:0]    bot_data_o;
  logic             right_valid_o;
  logic [CW-1:0]    right_cnt_o;
  logic             right_type_o;
  logic             right_precision_o;
  logic [DW-1:0]    right_data_o;
  logic             bot_res_valid_o;
  logic [ACC_W-1:0] bot_res_o;
  logic             err_o;

  modport slave (
    input  top_valid_i, top_cnt_i, top_data_i,
    input  left_valid_i, left_cnt_i, left_type_i, left_precision_i, left_data_i,
    input  cap_i, shift_i, top_res_valid_i, top_res_i,
    output bot_valid_o, bot_cnt_o, bot_data_o,
    output right_valid_o, right_cnt_o, right_type_o, right_precision_o, right_data_o,
    output bot_res_valid_o, bot_res_o, err_o
  );

  modport master (
    output top_valid_i, top_cnt_i, top_data_i,
    output left_valid_i, left_cnt_i, left_type_i, left_precision_i, left_data_i,
    output cap_i, shift_i, top_res_valid_i, top_res_i,
    input  bot_valid_o, bot_cnt_o, bot_data_o,
    input  right_valid_o, right_cnt_o, right_type_o, right_precision_o, right_data_o,
    input  bot_res_valid_o, bot_res_o, err_o
  );
endinterface

// File: rtl/pe_os.sv
// Output-stationary systolic PE: registered A/B forwarding, packed-precision MAC
// into a wide wrapping accumulator, C preload, and a column result drain chain.
module pe_os #(
  parameter int X     = 0,
  parameter int Y     = 0,
  parameter int DW    = 16,
  parameter int ACC_W = 40,
  parameter int CW    = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  pe_os_if.slave   bus
);
  localparam int H = DW / 2;

  typedef logic signed [ACC_W-1:0] acc_t;

  if ((DW % 2) != 0 || ACC_W < 2 * DW + 1 || X < 0 || Y < 0) begin : g_bad_params
    $error("pe_os: illegal parameter combination");
  end

  // Packed mode sums two half-width signed lane products; lane products fit easily in ACC_W.
  function automatic acc_t mac_product(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic prec);
    acc_t p_full;
    acc_t p_hi;
    acc_t p_lo;
    p_full = acc_t'($signed(a)) * acc_t'($signed(b));
    p_hi   = acc_t'($signed(a[DW-1:H])) * acc_t'($signed(b[DW-1:H]));
    p_lo   = acc_t'($signed(a[H-1:0])) * acc_t'($signed(b[H-1:0]));
    return prec ? (p_hi + p_lo) : p_full;
  endfunction

  logic          w_mac_fire;
  logic          w_pre_fire;
  logic          w_cnt_zero;
  acc_t          w_prod;

  logic          r_right_valid_p1;
  logic [CW-1:0] r_right_cnt_p1;
  logic          r_right_type_p1;
  logic          r_right_prec_p1;
  logic [DW-1:0] r_right_data_p1;
  logic          r_bot_valid_p1;
  logic [CW-1:0] r_bot_cnt_p1;
  logic [DW-1:0] r_bot_data_p1;

  acc_t          r_acc;
  acc_t          r_res;
  logic          r_res_vld;
  acc_t          r_bot_res;
  logic          r_bot_res_vld;
  logic          r_err;

  assign w_mac_fire = bus.top_valid_i & bus.left_valid_i & ~bus.left_type_i;
  assign w_pre_fire = bus.left_valid_i & bus.left_type_i;
  assign w_cnt_zero = (bus.left_cnt_i == '0);
  assign w_prod     = mac_product(bus.left_data_i, bus.top_data_i, bus.left_precision_i);

  // Stage p1: one-cycle forwarding of A/C words right and B words down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_right_valid_p1 <= 1'b0;
      r_right_cnt_p1   <= '0;
      r_right_type_p1  <= 1'b0;
      r_right_prec_p1  <= 1'b0;
      r_right_data_p1  <= '0;
      r_bot_valid_p1   <= 1'b0;
      r_bot_cnt_p1     <= '0;
      r_bot_data_p1    <= '0;
    end else begin
      r_right_valid_p1 <= bus.left_valid_i;
      r_right_cnt_p1   <= bus.left_cnt_i;
      r_right_type_p1  <= bus.left_type_i;
      r_right_prec_p1  <= bus.left_precision_i;
      r_right_data_p1  <= bus.left_data_i;
      r_bot_valid_p1   <= bus.top_valid_i;
      r_bot_cnt_p1     <= bus.top_cnt_i;
      r_bot_data_p1    <= bus.top_data_i;
    end
  end

  // Stage acc: preload beats a tile start, which beats a plain accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_pre_fire) begin
      r_acc <= acc_t'($signed(bus.left_data_i));
    end else if (w_mac_fire && w_cnt_zero) begin
      r_acc <= w_prod;
    end else if (w_mac_fire) begin
      r_acc <= r_acc + w_prod;
    end
  end

  // Stage drain: capture takes the pre-update accumulator and blocks this PE's shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res         <= '0;
      r_res_vld     <= 1'b0;
      r_bot_res     <= '0;
      r_bot_res_vld <= 1'b0;
    end else if (bus.cap_i) begin
      r_res         <= r_acc;
      r_res_vld     <= 1'b1;
      r_bot_res_vld <= 1'b0;
    end else if (bus.shift_i) begin
      r_bot_res     <= r_res;
      r_bot_res_vld <= r_res_vld;
      r_res         <= bus.top_res_i;
      r_res_vld     <= bus.top_res_valid_i;
    end else begin
      r_bot_res_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_mac_fire && (bus.top_cnt_i != bus.left_cnt_i)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.right_valid_o     = r_right_valid_p1;
  assign bus.right_cnt_o       = r_right_cnt_p1;
  assign bus.right_type_o      = r_right_type_p1;
  assign bus.right_precision_o = r_right_prec_p1;
  assign bus.right_data_o      = r_right_data_p1;
  assign bus.bot_valid_o       = r_bot_valid_p1;
  assign bus.bot_cnt_o         = r_bot_cnt_p1;
  assign bus.bot_data_o        = r_bot_data_p1;
  assign bus.bot_res_valid_o   = r_bot_res_vld;
  assign bus.bot_res_o         = r_bot_res;
  assign bus.err_o             = r_err;
endmodule

// File: tb/tb_pe_os.sv
// Bench for pe_os: directed table, multi-cycle corner sequences and random
// traffic, all checked against an arithmetic reference model.
module tb_pe_os;
  localparam int DW = 16;
  localparam int ACC_W = 40;
  localparam int CW = 8;

  typedef struct {
    logic        tv;
    logic [7:0]  tcnt;
    logic [15:0] tdata;
    logic        lv;
    logic [7:0]  lcnt;
    logic        ltype;
    logic        lprec;
    logic [15:0] ldata;
    logic        cap;
    logic        shift;
    logic        trv;
    logic [39:0] tres;
  } in_t;

  typedef struct {
    in_t         in;
    logic        bv;
    logic [39:0] bres;
    logic        err;
    logic [15:0] rdata;
    logic        rtype;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  cur;
  int   total = 0;
  int   bad = 0;

  // reference model state
  in_t         pv;
  longint      m_acc;
  logic [39:0] m_res;
  logic        m_resv;
  logic [39:0] m_bres;
  logic        m_bv;
  logic        m_err;

  pe_os_if #(.DW(DW), .ACC_W(ACC_W), .CW(CW)) bus ();

  pe_os #(.X(0), .Y(0), .DW(DW), .ACC_W(ACC_W), .CW(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.top_valid_i      = cur.tv;
  assign bus.top_cnt_i        = cur.tcnt;
  assign bus.top_data_i       = cur.tdata;
  assign bus.left_valid_i     = cur.lv;
  assign bus.left_cnt_i       = cur.lcnt;
  assign bus.left_type_i      = cur.ltype;
  assign bus.left_precision_i = cur.lprec;
  assign bus.left_data_i      = cur.ldata;
  assign bus.cap_i            = cur.cap;
  assign bus.shift_i          = cur.shift;
  assign bus.top_res_valid_i  = cur.trv;
  assign bus.top_res_i        = cur.tres;

  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t r;
    r = '{tv: 1'b0, tcnt: 8'd0, tdata: 16'd0, lv: 1'b0, lcnt: 8'd0, ltype: 1'b0,
          lprec: 1'b0, ldata: 16'd0, cap: 1'b0, shift: 1'b0, trv: 1'b0, tres: 40'd0};
    return r;
  endfunction

  function automatic in_t mk_mac(input logic [7:0] tc, input logic [7:0] lc,
                                 input logic [15:0] a, input logic [15:0] b, input logic prec);
    in_t r;
    r = idle();
    r.tv = 1'b1; r.lv = 1'b1; r.tcnt = tc; r.lcnt = lc;
    r.ldata = a; r.tdata = b; r.lprec = prec;
    return r;
  endfunction

  function automatic in_t mk_pre(input logic [15:0] d);
    in_t r;
    r = idle();
    r.lv = 1'b1; r.ltype = 1'b1; r.ldata = d;
    return r;
  endfunction

  function automatic in_t mk_cap();
    in_t r;
    r = idle();
    r.cap = 1'b1;
    return r;
  endfunction

  function automatic in_t mk_shift(input logic [39:0] tr, input logic trv);
    in_t r;
    r = idle();
    r.shift = 1'b1; r.tres = tr; r.trv = trv;
    return r;
  endfunction

  function automatic longint lane_hi(input int v);
    return longint'(v >>> 8);
  endfunction

  function automatic longint lane_lo(input int v);
    int u;
    u = v & 255;
    return longint'((u >= 128) ? u - 256 : u);
  endfunction

  function automatic longint ref_prod(input logic [15:0] a, input logic [15:0] b, input logic prec);
    int ai;
    int bi;
    ai = $signed(a);
    bi = $signed(b);
    if (!prec) return longint'(ai) * longint'(bi);
    return lane_hi(ai) * lane_hi(bi) + lane_lo(ai) * lane_lo(bi);
  endfunction

  function automatic longint wrap40(input longint x);
    logic [39:0] t;
    t = x[39:0];
    return longint'($signed(t));
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    pv = idle();
    m_acc = 0; m_res = '0; m_resv = 1'b0; m_bres = '0; m_bv = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_update();
    logic   mac;
    logic   pre;
    longint prod;
    longint old_acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    mac = cur.tv && cur.lv && !cur.ltype;
    pre = cur.lv && cur.ltype;
    prod = ref_prod(cur.ldata, cur.tdata, cur.lprec);
    old_acc = m_acc;
    if (pre) m_acc = longint'($signed(cur.ldata));
    else if (mac && cur.lcnt == 0) m_acc = prod;
    else if (mac) m_acc = wrap40(m_acc + prod);
    if (cur.cap) begin
      m_res = old_acc[39:0]; m_resv = 1'b1; m_bv = 1'b0;
    end else if (cur.shift) begin
      m_bres = m_res; m_bv = m_resv; m_res = cur.tres; m_resv = cur.trv;
    end else begin
      m_bv = 1'b0;
    end
    if (mac && cur.tcnt != cur.lcnt) m_err = 1'b1;
    pv = cur;
  endtask

  task automatic check_all();
    chk("right_valid", 64'(bus.right_valid_o), 64'(pv.lv));
    chk("right_cnt", 64'(bus.right_cnt_o), 64'(pv.lcnt));
    chk("right_type", 64'(bus.right_type_o), 64'(pv.ltype));
    chk("right_prec", 64'(bus.right_precision_o), 64'(pv.lprec));
    chk("right_data", 64'(bus.right_data_o), 64'(pv.ldata));
    chk("bot_valid", 64'(bus.bot_valid_o), 64'(pv.tv));
    chk("bot_cnt", 64'(bus.bot_cnt_o), 64'(pv.tcnt));
    chk("bot_data", 64'(bus.bot_data_o), 64'(pv.tdata));
    chk("bot_res_valid", 64'(bus.bot_res_valid_o), 64'(m_bv));
    chk("bot_res", 64'(bus.bot_res_o), 64'(m_bres));
    chk("err", 64'(bus.err_o), 64'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic drv(input in_t v);
    cur = v;
    step();
  endtask

  vec_t tbl[16];

  initial begin
    cur = idle();
    model_reset();
    tbl[0]  = '{mk_mac(8'd0, 8'd0, 16'd3, 16'd4, 1'b0),         1'b0, 40'd0,            1'b0, 16'd3,      1'b0};
    tbl[1]  = '{mk_mac(8'd1, 8'd1, 16'hFFFE, 16'd5, 1'b0),      1'b0, 40'd0,            1'b0, 16'hFFFE,   1'b0};
    tbl[2]  = '{mk_mac(8'd2, 8'd2, 16'd7, 16'hFFFF, 1'b0),      1'b0, 40'd0,            1'b0, 16'd7,      1'b0};
    tbl[3]  = '{mk_mac(8'd3, 8'd3, 16'd1, 16'd100, 1'b0),       1'b0, 40'd0,            1'b0, 16'd1,      1'b0};
    tbl[4]  = '{mk_cap(),                                        1'b0, 40'd0,            1'b0, 16'd0,      1'b0};
    tbl[5]  = '{mk_shift(40'd0, 1'b0),                           1'b1, 40'd95,           1'b0, 16'd0,      1'b0};
    tbl[6]  = '{idle(),                                          1'b0, 40'd95,           1'b0, 16'd0,      1'b0};
    tbl[7]  = '{mk_mac(8'd0, 8'd0, 16'h02FD, 16'h0304, 1'b1),   1'b0, 40'd95,           1'b0, 16'h02FD,   1'b0};
    tbl[8]  = '{mk_cap(),                                        1'b0, 40'd95,           1'b0, 16'd0,      1'b0};
    tbl[9]  = '{mk_shift(40'd0, 1'b0),                           1'b1, 40'hFF_FFFF_FFFA, 1'b0, 16'd0,      1'b0};
    tbl[10] = '{mk_pre(16'hFFF6),                                1'b0, 40'hFF_FFFF_FFFA, 1'b0, 16'hFFF6,   1'b1};
    tbl[11] = '{mk_mac(8'd1, 8'd1, 16'd2, 16'd3, 1'b0),         1'b0, 40'hFF_FFFF_FFFA, 1'b0, 16'd2,      1'b0};
    tbl[12] = '{mk_cap(),                                        1'b0, 40'hFF_FFFF_FFFA, 1'b0, 16'd0,      1'b0};
    tbl[13] = '{mk_shift(40'd0, 1'b0),                           1'b1, 40'hFF_FFFF_FFFC, 1'b0, 16'd0,      1'b0};
    tbl[14] = '{mk_mac(8'd2, 8'd3, 16'd1, 16'd1, 1'b0),         1'b0, 40'hFF_FFFF_FFFC, 1'b1, 16'd1,      1'b0};
    tbl[15] = '{mk_mac(8'd1, 8'd1, 16'd1, 16'd1, 1'b0),         1'b0, 40'hFF_FFFF_FFFC, 1'b1, 16'd1,      1'b0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset in the middle of a tile with err set and outputs busy
    drv(mk_mac(8'd1, 8'd0, 16'd5, 16'd5, 1'b0));
    drv(mk_pre(16'd500));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_right_valid", 64'(bus.right_valid_o), 64'd0);
    chk("rst_right_data", 64'(bus.right_data_o), 64'd0);
    chk("rst_bot_valid", 64'(bus.bot_valid_o), 64'd0);
    chk("rst_bot_data", 64'(bus.bot_data_o), 64'd0);
    chk("rst_bot_res_valid", 64'(bus.bot_res_valid_o), 64'd0);
    chk("rst_bot_res", 64'(bus.bot_res_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    model_reset();
    cur = idle();
    @(negedge clk);
    rst_n = 1'b1;
    drv(mk_cap());
    drv(mk_shift(40'd0, 1'b0));
    chk("post_rst_res_valid", 64'(bus.bot_res_valid_o), 64'd1);
    chk("post_rst_res", 64'(bus.bot_res_o), 64'd0);

    for (int i = 0; i < 16; i++) begin
      drv(tbl[i].in);
      chk($sformatf("tbl%0d_bot_res_valid", i), 64'(bus.bot_res_valid_o), 64'(tbl[i].bv));
      chk($sformatf("tbl%0d_bot_res", i), 64'(bus.bot_res_o), 64'(tbl[i].bres));
      chk($sformatf("tbl%0d_err", i), 64'(bus.err_o), 64'(tbl[i].err));
      chk($sformatf("tbl%0d_right_data", i), 64'(bus.right_data_o), 64'(tbl[i].rdata));
      chk($sformatf("tbl%0d_right_type", i), 64'(bus.right_type_o), 64'(tbl[i].rtype));
    end

    // accumulator wrap: build 2^39-1, capture it alongside the final +1, then see -2^39
    drv(mk_mac(8'd0, 8'd0, 16'h8000, 16'h8000, 1'b0));
    for (int i = 0; i < 510; i++) drv(mk_mac(8'd1, 8'd1, 16'h8000, 16'h8000, 1'b0));
    drv(mk_mac(8'd1, 8'd1, 16'h7FFF, 16'h7FFF, 1'b0));
    drv(mk_mac(8'd1, 8'd1, 16'd2, 16'h7FFF, 1'b0));
    cur = mk_mac(8'd1, 8'd1, 16'd1, 16'd1, 1'b0);
    cur.cap = 1'b1;
    step();
    drv(mk_shift(40'd0, 1'b0));
    chk("wrap_max_res", 64'(bus.bot_res_o), 64'h7F_FFFF_FFFF);
    drv(mk_cap());
    drv(mk_shift(40'd0, 1'b0));
    chk("wrap_min_res", 64'(bus.bot_res_o), 64'h80_0000_0000);
    chk("wrap_min_valid", 64'(bus.bot_res_valid_o), 64'd1);

    // column drain as seen from the bottom PE, then cap colliding with shift
    drv(mk_pre(16'd40));
    drv(mk_cap());
    drv(mk_shift(40'd30, 1'b1));
    chk("drain0", 64'({bus.bot_res_valid_o, bus.bot_res_o}), {23'd0, 1'b1, 40'd40});
    drv(mk_shift(40'd20, 1'b1));
    chk("drain1", 64'({bus.bot_res_valid_o, bus.bot_res_o}), {23'd0, 1'b1, 40'd30});
    drv(mk_shift(40'd10, 1'b1));
    chk("drain2", 64'({bus.bot_res_valid_o, bus.bot_res_o}), {23'd0, 1'b1, 40'd20});
    drv(mk_shift(40'd0, 1'b0));
    chk("drain3", 64'({bus.bot_res_valid_o, bus.bot_res_o}), {23'd0, 1'b1, 40'd10});
    drv(mk_shift(40'd0, 1'b0));
    chk("drain4_valid", 64'(bus.bot_res_valid_o), 64'd0);
    drv(mk_pre(16'd7));
    cur = mk_shift(40'd99, 1'b1);
    cur.cap = 1'b1;
    step();
    chk("capshift_valid", 64'(bus.bot_res_valid_o), 64'd0);
    drv(mk_shift(40'd0, 1'b0));
    chk("capshift_res", 64'({bus.bot_res_valid_o, bus.bot_res_o}), {23'd0, 1'b1, 40'd7});

    // random traffic with one asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rnd_rst_err", 64'(bus.err_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      cur.tv    = ($urandom_range(0, 3) != 0);
      cur.lv    = ($urandom_range(0, 3) != 0);
      cur.ltype = ($urandom_range(0, 9) == 0);
      cur.lprec = 1'($urandom_range(0, 1));
      cur.lcnt  = 8'($urandom_range(0, 3));
      cur.tcnt  = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 3)) : cur.lcnt;
      cur.ldata = 16'($urandom());
      cur.tdata = 16'($urandom());
      cur.cap   = ($urandom_range(0, 7) == 0);
      cur.shift = ($urandom_range(0, 2) == 0);
      cur.trv   = 1'($urandom_range(0, 1));
      cur.tres  = 40'({$urandom(), $urandom()});
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
